// File: rtl/ir_pkg.sv
// Shared widths and handshake state encoding for the instruction queue.
package ir_pkg;

  localparam int IR_MNM_W  = 2;
  localparam int IR_ADDR_W = 2;
  localparam int IR_DATA_W = 4;
  localparam int IR_DEPTH  = 4;

  typedef enum logic {
    IR_IDLE,
    IR_ACK
  } ir_state_t;

endpackage

// File: rtl/ir_fifo.sv
// Circular instruction store: pointers wrap modulo DEPTH, count tracks 0..DEPTH exactly.
module ir_fifo import ir_pkg::*; #(
  parameter int WIDTH = IR_MNM_W + IR_ADDR_W + IR_DATA_W,
  parameter int DEPTH = IR_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_i,
  input  logic                       rd_i,
  input  logic [WIDTH-1:0]           wdata_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q, rdPtr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             doWrite, doRead;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rdPtr_q];

  // A write into a full store is only legal when the head leaves on the same edge.
  always_comb begin
    doRead  = rd_i && !empty_o;
    doWrite = wr_i && (!full_o || doRead);
    count_d = count_q;
    case ({doWrite, doRead})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (doWrite) mem_q[wrPtr_q] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doWrite) wrPtr_q <= wrPtr_q + PTR_W'(1);
      if (doRead)  rdPtr_q <= rdPtr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/instruction_queue.sv
// Bus-side ena/ack handshake in front of a FWFT instruction store; head word split into fields.
// Define IR_PARITY_EN to add the par_in/perr even-parity reject path.
module instruction_queue import ir_pkg::*; #(
  parameter int MNM_W  = IR_MNM_W,
  parameter int ADDR_W = IR_ADDR_W,
  parameter int DATA_W = IR_DATA_W,
  parameter int DEPTH  = IR_DEPTH
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [MNM_W+ADDR_W+DATA_W-1:0]  data_in,
  input  logic                            ena,
  output logic                            ack,
  input  logic                            pop,
  output logic [MNM_W-1:0]                mnm,
  output logic [ADDR_W-1:0]               wr_addr_mnm,
  output logic [DATA_W-1:0]               rd_addr_wr_data,
  output logic                            valid,
  output logic                            full,
`ifdef IR_PARITY_EN
  input  logic                            par_in,
  output logic                            perr,
`endif
  output logic [$clog2(DEPTH+1)-1:0]      count
);

  localparam int INSTR_W = MNM_W + ADDR_W + DATA_W;

  ir_state_t          state_q;
  logic               ack_q;
  logic               fifoFull, fifoEmpty;
  logic               spaceAvail, accept, parityOk, wrStrobe, rdStrobe;
  logic [INSTR_W-1:0] headRaw, headWord;

`ifdef IR_PARITY_EN
  logic perr_q;
  assign parityOk = ~^{data_in, par_in};
  assign perr     = perr_q;
`else
  assign parityOk = 1'b1;
`endif

  // A pop on the same edge frees the slot, so a full queue can still accept.
  assign spaceAvail = !fifoFull || pop;
  assign accept     = (state_q == IR_IDLE) && ena && spaceAvail;
  assign wrStrobe   = accept && parityOk;
  assign rdStrobe   = pop && !fifoEmpty;

  ir_fifo #(.WIDTH(INSTR_W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_i    (wrStrobe),
    .rd_i    (rdStrobe),
    .wdata_i (data_in),
    .rdata_o (headRaw),
    .count_o (count),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IR_IDLE;
      ack_q   <= 1'b0;
`ifdef IR_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
`ifdef IR_PARITY_EN
      perr_q <= 1'b0;
`endif
      case (state_q)
        IR_IDLE: begin
          if (accept) begin
            ack_q   <= 1'b1;
            state_q <= IR_ACK;
`ifdef IR_PARITY_EN
            perr_q  <= !parityOk;
`endif
          end
        end
        IR_ACK: begin
          if (!ena) begin
            ack_q   <= 1'b0;
            state_q <= IR_IDLE;
          end
        end
        default: begin
          ack_q   <= 1'b0;
          state_q <= IR_IDLE;
        end
      endcase
    end
  end

  // Empty queue presents zeroed fields rather than stale storage.
  assign headWord        = fifoEmpty ? '0 : headRaw;
  assign ack             = ack_q;
  assign valid           = !fifoEmpty;
  assign full            = fifoFull;
  assign mnm             = headWord[INSTR_W-1 -: MNM_W];
  assign wr_addr_mnm     = headWord[DATA_W +: ADDR_W];
  assign rd_addr_wr_data = headWord[DATA_W-1:0];

endmodule

// File: tb/tb_instruction_queue.sv
// Directed-vector bench for instruction_queue (DEPTH=4, 8-bit instructions).
module tb_instruction_queue;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_in;
  logic       ena, pop, ack, valid, full;
  logic [1:0] mnm, wr_addr_mnm;
  logic [3:0] rd_addr_wr_data;
  logic [2:0] count;
`ifdef IR_PARITY_EN
  logic par_in, perr;
`endif

  int vectors = 0;
  int miscompares = 0;

  instruction_queue dut (
    .clk             (clk),
    .rst             (rst),
    .data_in         (data_in),
    .ena             (ena),
    .ack             (ack),
    .pop             (pop),
    .mnm             (mnm),
    .wr_addr_mnm     (wr_addr_mnm),
    .rd_addr_wr_data (rd_addr_wr_data),
    .valid           (valid),
    .full            (full),
`ifdef IR_PARITY_EN
    .par_in          (par_in),
    .perr            (perr),
`endif
    .count           (count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  function automatic logic [7:0] headWord();
    return {mnm, wr_addr_mnm, rd_addr_wr_data};
  endfunction

  // Full four-phase write of one word, each wait bounded.
  task automatic applyStimulus(input logic [7:0] word);
    logic seen;
    data_in = word;
`ifdef IR_PARITY_EN
    par_in = ^word;
`endif
    ena = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      tick();
      if (ack) seen = 1'b1;
    end
    checkOutput("ackRise", 32'(seen), 32'd1);
    ena = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      tick();
      if (!ack) seen = 1'b1;
    end
    checkOutput("ackFall", 32'(seen), 32'd1);
  endtask

  task automatic popOnce();
    pop = 1'b1;
    tick();
    pop = 1'b0;
  endtask

  logic [7:0] drainExp [4];
  logic [7:0] prevWord, nextWord;

  initial begin
    rst = 1'b0; ena = 1'b0; pop = 1'b0; data_in = 8'h00;
`ifdef IR_PARITY_EN
    par_in = 1'b0;
`endif
    tick(); tick();
    checkOutput("rstAck",   32'(ack),   32'd0);
    checkOutput("rstValid", 32'(valid), 32'd0);
    checkOutput("rstCount", 32'(count), 32'd0);
    checkOutput("rstFull",  32'(full),  32'd0);
    checkOutput("rstHead",  32'(headWord()), 32'h00);
    rst = 1'b1;
    tick();

    // single handshake, ena held for three edges
    data_in = 8'hA5;
`ifdef IR_PARITY_EN
    par_in = ^8'hA5;
`endif
    ena = 1'b1;
    tick();
    checkOutput("a5Ack1",  32'(ack),   32'd1);
    checkOutput("a5Valid", 32'(valid), 32'd1);
    checkOutput("a5Count", 32'(count), 32'd1);
    checkOutput("a5Mnm",   32'(mnm),   32'h2);
    checkOutput("a5Wr",    32'(wr_addr_mnm), 32'h2);
    checkOutput("a5Rd",    32'(rd_addr_wr_data), 32'h5);
    tick(); tick();
    checkOutput("a5Ack3",  32'(ack),   32'd1);
    checkOutput("a5Count3", 32'(count), 32'd1);
    ena = 1'b0;
    tick();
    checkOutput("a5AckDrop", 32'(ack), 32'd0);
    popOnce();
    checkOutput("a5PopCount", 32'(count), 32'd0);
    checkOutput("a5PopValid", 32'(valid), 32'd0);

    // fill to DEPTH, then stall and pop-while-full
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    applyStimulus(8'h33);
    applyStimulus(8'h44);
    checkOutput("fillFull",  32'(full),  32'd1);
    checkOutput("fillCount", 32'(count), 32'd4);
    checkOutput("fillHead",  32'(headWord()), 32'h11);
    data_in = 8'h55;
`ifdef IR_PARITY_EN
    par_in = ^8'h55;
`endif
    ena = 1'b1;
    tick(); tick();
    checkOutput("stallAck",   32'(ack),   32'd0);
    checkOutput("stallCount", 32'(count), 32'd4);
    pop = 1'b1;
    tick();
    pop = 1'b0;
    checkOutput("popWrAck",   32'(ack),   32'd1);
    checkOutput("popWrCount", 32'(count), 32'd4);
    checkOutput("popWrFull",  32'(full),  32'd1);
    checkOutput("popWrHead",  32'(headWord()), 32'h22);
    ena = 1'b0;
    tick();
    checkOutput("popWrAckFall", 32'(ack), 32'd0);
    drainExp = '{8'h22, 8'h33, 8'h44, 8'h55};
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("drain%0d", i), 32'(headWord()), 32'(drainExp[i]));
      popOnce();
    end
    checkOutput("drainCount", 32'(count), 32'd0);
    checkOutput("drainFull",  32'(full),  32'd0);

    // pop on empty is ignored
    popOnce();
    checkOutput("underCount", 32'(count), 32'd0);
    checkOutput("underValid", 32'(valid), 32'd0);
    checkOutput("underHead",  32'(headWord()), 32'h00);

    // write and pop on the same edge into an empty queue: write wins
    data_in = 8'h3C;
`ifdef IR_PARITY_EN
    par_in = ^8'h3C;
`endif
    ena = 1'b1; pop = 1'b1;
    tick();
    pop = 1'b0; ena = 1'b0;
    checkOutput("emptyWrPopCount", 32'(count), 32'd1);
    checkOutput("emptyWrPopHead",  32'(headWord()), 32'h3C);
    tick();
    popOnce();

    // pointer wrap with two entries in flight
    prevWord = 8'h80;
    applyStimulus(prevWord);
    for (int i = 0; i < 6; i++) begin
      nextWord = 8'h81 + 8'(i) * 8'h13;
      applyStimulus(nextWord);
      checkOutput($sformatf("wrapCount%0d", i), 32'(count), 32'd2);
      checkOutput($sformatf("wrapHead%0d", i), 32'(headWord()), 32'(prevWord));
      popOnce();
      prevWord = nextWord;
    end
    checkOutput("wrapLast", 32'(headWord()), 32'(prevWord));
    popOnce();
    checkOutput("wrapEmpty", 32'(count), 32'd0);

    // asynchronous reset mid-handshake with three entries held
    applyStimulus(8'hA1);
    applyStimulus(8'hB2);
    data_in = 8'hC3;
`ifdef IR_PARITY_EN
    par_in = ^8'hC3;
`endif
    ena = 1'b1;
    tick();
    checkOutput("preRstAck",   32'(ack),   32'd1);
    checkOutput("preRstCount", 32'(count), 32'd3);
    #2 rst = 1'b0;
    #1;
    checkOutput("asyncAck",   32'(ack),   32'd0);
    checkOutput("asyncValid", 32'(valid), 32'd0);
    checkOutput("asyncCount", 32'(count), 32'd0);
    checkOutput("asyncFull",  32'(full),  32'd0);
    tick();
    checkOutput("heldRstCount", 32'(count), 32'd0);
    ena = 1'b0;
    rst = 1'b1;
    tick();
    checkOutput("postRstCount", 32'(count), 32'd0);
    checkOutput("postRstAck",   32'(ack),   32'd0);

`ifdef IR_PARITY_EN
    // bad parity: handshake completes, word dropped, one-cycle perr
    data_in = 8'h01; par_in = 1'b0; ena = 1'b1;
    tick();
    checkOutput("parBadAck",   32'(ack),   32'd1);
    checkOutput("parBadPerr",  32'(perr),  32'd1);
    checkOutput("parBadCount", 32'(count), 32'd0);
    tick();
    checkOutput("parBadPerrLow", 32'(perr), 32'd0);
    ena = 1'b0;
    tick();
    data_in = 8'h01; par_in = 1'b1; ena = 1'b1;
    tick();
    checkOutput("parOkPerr",  32'(perr),  32'd0);
    checkOutput("parOkCount", 32'(count), 32'd1);
    checkOutput("parOkHead",  32'(headWord()), 32'h01);
    ena = 1'b0;
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
